// File: rtl/sgd_loss_sched_pkg.sv
// Shared types and constants for the serial-loss read scheduler.
// Holds the FSM state enum, credit width helper and default sizing.
package sgd_loss_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        POP,
        DRAIN
    } state_e;

    localparam int DEF_CREDITS       = 16;
    localparam int DEF_ALIGN_TIMEOUT = 256;

    // Width needed to hold a credit count of 0..n inclusive.
    function automatic int cred_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sgd_credit_counter.sv
// Up/down saturating counter, reset to MAX, with an overflow flag.
// Ports: clk, rst, inc_i, dec_i, cnt_o, cnt_nxt_o, ovf_o (inc while full).
module sgd_credit_counter #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] FULL = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        unique case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q == FULL) ovf_o = 1'b1;
                else               cnt_d = cnt_q + 1'b1;
            end
            2'b01: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= FULL;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/sgd_loss_rd_sched.sv
// Aligned pop scheduler for the engine dot-product FIFOs and the b FIFO:
// paces pops by a gap, tracks credits, counts samples, pulses done,
// and flags engine misalignment via a watchdog and credit overflow.
// Ports: clk, rst, start, cfg_num_samples, cfg_rd_gap, a_empty, b_empty,
//   result_retire (in); a_rd_en, busy, done, err_align, credits_avail (out).
// Macro SGD_LOSS_SCHED_STATS_EN adds stat_pops and stat_stall_cycles.
module sgd_loss_rd_sched
    import sgd_loss_sched_pkg::*;
#(
    parameter int ENGINE_NUM    = 8,
    parameter int CREDITS       = DEF_CREDITS,
    parameter int ALIGN_TIMEOUT = DEF_ALIGN_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [31:0]                cfg_num_samples,
    input  logic [3:0]                 cfg_rd_gap,
    input  logic [ENGINE_NUM-1:0]      a_empty,
    input  logic                       b_empty,
    output logic [ENGINE_NUM-1:0]      a_rd_en,
    input  logic                       result_retire,
    output logic                       busy,
    output logic                       done,
    output logic                       err_align,
    output logic [cred_w(CREDITS)-1:0] credits_avail
`ifdef SGD_LOSS_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_pops,
    output logic [31:0]                stat_stall_cycles
`endif
);

    localparam int CW  = cred_w(CREDITS);
    localparam int WDW = $clog2(ALIGN_TIMEOUT + 1);
    localparam logic [CW-1:0]  CRED_FULL = CW'(CREDITS);
    localparam logic [WDW-1:0] WD_TO     = WDW'(ALIGN_TIMEOUT);

    state_e         state_q, state_d;
    logic [31:0]    num_q, num_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [3:0]     gcfg_q, gcfg_d;
    logic [3:0]     gap_q, gap_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           rd_q;

    logic [CW-1:0]  cred, cred_nxt;
    logic           ovf;
    logic           pop;
    logic           all_rdy;
    logic           partial;
    logic           pop_ok;

    assign pop     = (state_q == POP);
    assign all_rdy = ~|a_empty & ~b_empty;
    assign partial = |a_empty & ~&a_empty;
    assign pop_ok  = all_rdy && (cred != '0) && (gap_q == '0);

    sgd_credit_counter #(
        .MAX (CREDITS),
        .W   (CW)
    ) u_cred (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (result_retire),
        .dec_i     (pop),
        .cnt_o     (cred),
        .cnt_nxt_o (cred_nxt),
        .ovf_o     (ovf)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        gcfg_d  = gcfg_q;
        gap_d   = gap_q;
        wd_d    = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q | ovf;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = cfg_num_samples;
                    gcfg_d  = cfg_rd_gap;
                    cnt_d   = '0;
                    gap_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (cfg_num_samples == '0) ? DRAIN : ARM;
                end
            end
            ARM: begin
                if (gap_q != '0) gap_d = gap_q - 4'd1;
                if (partial) begin
                    wd_d = (wd_q == WD_TO) ? wd_q : wd_q + 1'b1;
                    if (wd_q == WD_TO - 1'b1) err_d = 1'b1;
                end
                if (pop_ok) state_d = POP;
            end
            POP: begin
                cnt_d = cnt_q + 32'd1;
                // The ARM cycle after a pop already counts as one idle cycle.
                gap_d = (gcfg_q == '0) ? '0 : gcfg_q - 4'd1;
                state_d = (cnt_q + 32'd1 == num_q) ? DRAIN : ARM;
            end
            DRAIN: begin
                // Looking at the next credit value lets done follow the
                // last retire by a single cycle.
                if (cred_nxt == CRED_FULL) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            gcfg_q  <= '0;
            gap_q   <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            gcfg_q  <= gcfg_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= (state_d == POP);
        end
    end

    assign a_rd_en       = {ENGINE_NUM{rd_q}};
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_align     = err_q;
    assign credits_avail = cred;

`ifdef SGD_LOSS_SCHED_STATS_EN
    logic [31:0] pops_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pops_q  <= '0;
            stall_q <= '0;
        end else if (state_q == IDLE && start) begin
            pops_q  <= '0;
            stall_q <= '0;
        end else begin
            if (pop && pops_q != '1)
                pops_q <= pops_q + 32'd1;
            if (state_q == ARM && gap_q == '0 && !pop_ok && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_pops         = pops_q;
    assign stat_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sgd_loss_rd_sched.sv
// Directed bench for sgd_loss_rd_sched: a cycle table plus
// hand-written sequences for pacing, credits, watchdog and reset.
module tb_sgd_loss_rd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_num_samples;
    logic [3:0]  cfg_rd_gap;
    logic [7:0]  a_empty;
    logic        b_empty;
    logic [7:0]  a_rd_en;
    logic        result_retire;
    logic        busy;
    logic        done;
    logic        err_align;
    logic [4:0]  credits_avail;

    int errors = 0;
    int checks = 0;
    int pt[$];
    int dn_t[$];
    int busy_at_done;
    int hit;

    always #5 clk = ~clk;

    sgd_loss_rd_sched dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_num_samples (cfg_num_samples),
        .cfg_rd_gap      (cfg_rd_gap),
        .a_empty         (a_empty),
        .b_empty         (b_empty),
        .a_rd_en         (a_rd_en),
        .result_retire   (result_retire),
        .busy            (busy),
        .done            (done),
        .err_align       (err_align),
        .credits_avail   (credits_avail)
    );

    typedef struct {
        logic        st;
        logic [31:0] num;
        logic [3:0]  gap;
        logic [7:0]  ae;
        logic        be;
        logic        ret;
        logic        rd;
        logic        bz;
        logic        dn;
        logic        er;
        logic [4:0]  cr;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        result_retire = 1'b0;
        a_empty = 8'h00;
        b_empty = 1'b0;
        cfg_num_samples = 32'd0;
        cfg_rd_gap = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic go(input int n, input int g);
        cfg_num_samples = n;
        cfg_rd_gap = 4'(g);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs ncyc cycles starting at cycle index c0, logging pops and done,
    // and retiring each pop rdly cycles later (rdly=0: never retire).
    task automatic run(input int ncyc, input int rdly, input int c0);
        int rq[$];
        for (int c = c0; c < c0 + ncyc; c++) begin
            if (a_rd_en == 8'hFF) begin
                pt.push_back(c);
                if (rdly > 0) rq.push_back(c + rdly);
            end
            if (done) begin
                dn_t.push_back(c);
                busy_at_done = busy;
            end
            result_retire = (rq.size() > 0 && rq[0] == c);
            if (result_retire) void'(rq.pop_front());
            tick();
        end
        result_retire = 1'b0;
    endtask

    initial begin
        tv[0]  = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16};
        tv[1]  = '{1'b1, 32'd2, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16};
        tv[2]  = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16};
        tv[3]  = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd16};
        tv[4]  = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15};
        tv[5]  = '{1'b0, 32'd0, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15};
        tv[6]  = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd15};
        tv[7]  = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15};
        tv[8]  = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16};
        tv[9]  = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16};
        tv[10] = '{1'b1, 32'd1, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16};
        tv[11] = '{1'b1, 32'd0, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16};
        tv[12] = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd16};
        tv[13] = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15};
        tv[14] = '{1'b0, 32'd0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16};

        do_reset();
        chk("rst_rd", a_rd_en, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_align, 0);
        chk("rst_cred", credits_avail, 16);

        for (int i = 0; i < 15; i++) begin
            start = tv[i].st;
            cfg_num_samples = tv[i].num;
            cfg_rd_gap = tv[i].gap;
            a_empty = tv[i].ae;
            b_empty = tv[i].be;
            result_retire = tv[i].ret;
            tick();
            chk($sformatf("tv%0d_rd", i), a_rd_en, tv[i].rd ? 8'hFF : 8'h00);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].bz);
            chk($sformatf("tv%0d_done", i), done, tv[i].dn);
            chk($sformatf("tv%0d_err", i), err_align, tv[i].er);
            chk($sformatf("tv%0d_cred", i), credits_avail, tv[i].cr);
        end
        start = 1'b0;
        result_retire = 1'b0;

        // Paced run: 4 samples, gap 2, retire 5 cycles after each pop.
        do_reset();
        pt.delete();
        dn_t.delete();
        go(4, 2);
        run(30, 5, 1);
        chk("pace_npops", pt.size(), 4);
        if (pt.size() == 4) begin
            chk("pace_first", pt[0], 2);
            for (int i = 1; i < 4; i++)
                chk($sformatf("pace_gap%0d", i), pt[i] - pt[i-1], 3);
            chk("pace_ndone", dn_t.size(), 1);
            if (dn_t.size() == 1)
                chk("pace_done_t", dn_t[0], pt[3] + 6);
            chk("pace_busy_at_done", busy_at_done, 0);
        end

        // Credit starvation: 20 samples, no retires.
        do_reset();
        pt.delete();
        go(20, 0);
        run(50, 0, 1);
        chk("starve_npops", pt.size(), 16);
        chk("starve_cred", credits_avail, 0);
        chk("starve_busy", busy, 1);
        result_retire = 1'b1;
        tick();
        result_retire = 1'b0;
        pt.delete();
        run(20, 0, 0);
        chk("starve_one_more", pt.size(), 1);
        chk("starve_cred2", credits_avail, 0);

        // Alignment watchdog with engine 0 stuck empty.
        do_reset();
        pt.delete();
        a_empty = 8'h01;
        go(1, 0);
        run(249, 0, 1);
        chk("wd_err_early", err_align, 0);
        run(8, 0, 250);
        chk("wd_err_set", err_align, 1);
        chk("wd_nopop", pt.size(), 0);
        a_empty = 8'h00;
        run(4, 0, 258);
        chk("wd_pop_after", pt.size(), 1);
        chk("wd_err_sticky", err_align, 1);
        result_retire = 1'b1;
        tick();
        result_retire = 1'b0;
        chk("wd_done", done, 1);
        go(0, 0);
        chk("wd_err_cleared", err_align, 0);
        tick();

        // Zero-sample run.
        do_reset();
        go(0, 0);
        chk("zero_busy1", busy, 1);
        chk("zero_done1", done, 0);
        tick();
        chk("zero_done2", done, 1);
        chk("zero_busy2", busy, 0);
        chk("zero_rd2", a_rd_en, 8'h00);
        tick();
        chk("zero_done3", done, 0);

        // Asynchronous reset after 3 of 10 pops, then a full rerun.
        do_reset();
        pt.delete();
        dn_t.delete();
        go(10, 0);
        run(5, 5, 1);
        chk("abort_pop3", a_rd_en, 8'hFF);
        chk("abort_npops", pt.size() + 1, 3);
        #2 rst = 1'b1;
        #1;
        chk("abort_rd", a_rd_en, 8'h00);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cred", credits_avail, 16);
        @(posedge clk);
        #1 rst = 1'b0;
        pt.delete();
        dn_t.delete();
        run(5, 0, 0);
        chk("abort_nodone", dn_t.size(), 0);
        go(10, 0);
        run(40, 5, 1);
        chk("rerun_npops", pt.size(), 10);
        chk("rerun_ndone", dn_t.size(), 1);

        // Simultaneous pop and retire at credits_avail=5.
        do_reset();
        hit = 0;
        go(20, 0);
        for (int c = 1; c < 40; c++) begin
            if (a_rd_en == 8'hFF && credits_avail == 5) begin
                result_retire = 1'b1;
                tick();
                result_retire = 1'b0;
                hit = 1;
                break;
            end
            tick();
        end
        chk("simul_hit", hit, 1);
        chk("simul_cred", credits_avail, 5);
        tick();
        tick();
        chk("simul_cred_next", credits_avail, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
